reorder_buff_vlane: RTL
=======================

Name: reorder_buff_vlane

Overview:
- Parametrised next-generation vector-unit reorder buffer for the TPU scalar-unit backend.
- Tracks each issued vector instruction against its enabled-lane mask, accumulating per-lane completion reports over multiple cycles and in any order.
- Retires entries strictly in issue order through a request/grant handshake to the commit logic.
- Adds an entry-index tag, an occupancy count, a flush, and sticky error detection.

Parameters:
- NUM_ENTRY, 16, buffer depth; power of two, at least 2.
- NUM_LANE, 16, number of vector lanes; width of the lane masks.
- WIDTH_ISSUE, 8, width of the issue number.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Flush  in  1  synchronous clear of all entries and pointers.
- I_Store  in  1  allocate-entry request.
- I_Issue_No  in  WIDTH_ISSUE  issue number to store.
- I_En_Lane  in  NUM_LANE  lanes participating in the stored instruction.
- O_Store_Ack  out  1  store accepted this cycle.
- O_Store_Idx  out  clog2(NUM_ENTRY)  entry index allocated; the issuing side returns this tag with completion reports.
- I_Done  in  1  lane-completion report valid.
- I_Done_Idx  in  clog2(NUM_ENTRY)  entry the report targets.
- I_Done_Lane  in  NUM_LANE  lanes reporting completion.
- O_Commit_Req  out  1  head entry fully complete; requesting commit.
- O_Commit_No  out  WIDTH_ISSUE  issue number of the head entry.
- I_Commit_Grant  in  1  commit accepted.
- O_Full  out  1  count == NUM_ENTRY.
- O_Empty  out  1  count == 0.
- O_Num  out  clog2(NUM_ENTRY)+1  occupancy count.
- O_Err  out  1  sticky protocol error.

Behaviour:
- Per-entry state:
  - v (1 bit)
  - issue_no (WIDTH_ISSUE)
  - en_lane (NUM_LANE)
  - done_lane (NUM_LANE)
- Pointers and count:
  - Head and tail pointers wrap modulo NUM_ENTRY.
  - Count is held in its own register, so Full and Empty are unambiguous.
- Reset (reset low, asynchronous):
  - All v, done_lane, head, tail, count and Err clear.
  - Resulting outputs: O_Empty=1, O_Full=0, O_Num=0, O_Commit_Req=0, O_Err=0, O_Store_Ack=0.
  - O_Store_Idx=0 and O_Commit_No=0, because entry contents are cleared.
- Store path:
  - O_Store_Ack = I_Store & ~O_Full, combinational.
  - O_Store_Idx = tail, combinational.
  - On ack, the entry at tail is written next edge: v=1, issue_no, en_lane, done_lane=0. Tail then increments.
  - A store while Full is dropped with no state change; O_Err is not set, because the issuer must watch O_Store_Ack.
- Done path:
  - If I_Done and entry[I_Done_Idx].v are both set: done_lane |= I_Done_Lane & en_lane.
  - If I_Done_Lane has bits outside en_lane, or the target entry is invalid, O_Err sets and stays set until reset or flush. Valid bits within the report are still merged.
- Completion condition:
  - An entry is complete when v & ((done_lane & en_lane) == en_lane).
  - An entry with an all-zero en_lane is complete as soon as it is stored.
- Commit path:
  - O_Commit_Req = head entry complete, combinational.
  - O_Commit_No = entry[head].issue_no.
  - Retire = O_Commit_Req & I_Commit_Grant. On retire the next edge clears entry[head].v and done_lane, and head increments.
  - A grant with no request is ignored.
  - At most one retire per cycle.
  - Younger complete entries wait until all older entries retire.
- Done report on the head in the same cycle:
  - The merged result counts only from the next cycle.
  - O_Commit_Req is based on registered state, so it asserts one cycle after the final lane report.
- Simultaneous store and retire:
  - Both occur.
  - Count is unchanged.
  - When Full, the store is rejected even if a retire happens in the same cycle, because Full comes from registered count.
- Count updates: +1 on store only, −1 on retire only, unchanged otherwise.
- Flush (I_Flush high at an edge):
  - Same clearing as reset, on that edge.
  - Overrides any store, done or retire in the same cycle.
  - O_Store_Ack and O_Commit_Req are forced to 0 during that cycle.
- Wrap-around:
  - Tail and head roll from NUM_ENTRY−1 to 0 with no gap.
  - Index tags are reused only after the entry has retired.

Test Plan:
- Reset then 3 stores with en_lane=16'h000F, issue 5,6,7 → O_Store_Idx 0,1,2; O_Num=3; O_Commit_Req=0.
- Out-of-order lanes: done idx0 lanes 16'h0003, then 16'h000C → O_Commit_Req=1, O_Commit_No=5 one cycle after the second report. With grant held, issues 5,6,7 retire on consecutive cycles once complete.
- In-order enforcement: complete idx1 fully while idx0 is pending → O_Commit_Req stays 0. Complete idx0 → commits 5 then 6.
- Fill 16 entries → O_Full=1. A 17th store → O_Store_Ack=0 with no change. Simultaneous store and grant when full → store rejected, O_Num=15 next cycle. Store and grant at O_Num=8 → O_Num stays 8. Wrap tail past 15 to 0.
- Done to invalid idx 9, or lane bit 16'h0100 outside en_lane=16'h000F → O_Err=1 and sticky. en_lane=0 store → O_Commit_Req the next cycle.
- Flush asserted with a concurrent store and grant → O_Num=0, O_Empty=1, O_Err=0, head=tail=0 next cycle. Reset low asynchronously mid-operation → outputs cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reorder_buff_vlane.sv
// In-order reorder buffer for vector instructions: collects per-lane completion reports in any
// order and retires the oldest fully completed entry through a request/grant handshake.
module reorder_buff_vlane #(
  parameter int unsigned NUM_ENTRY   = 16,
  parameter int unsigned NUM_LANE    = 16,
  parameter int unsigned WIDTH_ISSUE = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         I_Flush,
  input  logic                         I_Store,
  input  logic [WIDTH_ISSUE-1:0]       I_Issue_No,
  input  logic [NUM_LANE-1:0]          I_En_Lane,
  output logic                         O_Store_Ack,
  output logic [$clog2(NUM_ENTRY)-1:0] O_Store_Idx,
  input  logic                         I_Done,
  input  logic [$clog2(NUM_ENTRY)-1:0] I_Done_Idx,
  input  logic [NUM_LANE-1:0]          I_Done_Lane,
  output logic                         O_Commit_Req,
  output logic [WIDTH_ISSUE-1:0]       O_Commit_No,
  input  logic                         I_Commit_Grant,
  output logic                         O_Full,
  output logic                         O_Empty,
  output logic [$clog2(NUM_ENTRY):0]   O_Num,
  output logic                         O_Err
);

  localparam int unsigned IW = $clog2(NUM_ENTRY);
  localparam int unsigned CW = IW + 1;

  logic [NUM_ENTRY-1:0]   v_q, v_d;
  logic [WIDTH_ISSUE-1:0] issue_q [NUM_ENTRY];
  logic [WIDTH_ISSUE-1:0] issue_d [NUM_ENTRY];
  logic [NUM_LANE-1:0]    en_q    [NUM_ENTRY];
  logic [NUM_LANE-1:0]    en_d    [NUM_ENTRY];
  logic [NUM_LANE-1:0]    done_q  [NUM_ENTRY];
  logic [NUM_LANE-1:0]    done_d  [NUM_ENTRY];
  logic [IW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic head_complete, store_ack, commit_req, retire;

  assign O_Full        = (cnt_q == CW'(NUM_ENTRY));
  assign O_Empty       = (cnt_q == '0);
  assign O_Num         = cnt_q;
  assign O_Err         = err_q;
  assign O_Store_Idx   = tail_q;
  assign O_Commit_No   = issue_q[head_q];
  assign head_complete = v_q[head_q] & ((done_q[head_q] & en_q[head_q]) == en_q[head_q]);
  // Flush suppresses both handshakes so the issuer never sees an ack for a dropped store.
  assign store_ack     = I_Store & ~O_Full & ~I_Flush;
  assign commit_req    = head_complete & ~I_Flush;
  assign retire        = commit_req & I_Commit_Grant;
  assign O_Store_Ack   = store_ack;
  assign O_Commit_Req  = commit_req;

  always_comb begin
    v_d    = v_q;
    issue_d = issue_q;
    en_d   = en_q;
    done_d = done_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (I_Flush) begin
      v_d    = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        issue_d[i] = '0;
        en_d[i]    = '0;
        done_d[i]  = '0;
      end
    end else begin
      if (I_Done) begin
        if (v_q[I_Done_Idx]) begin
          done_d[I_Done_Idx] = done_q[I_Done_Idx] | (I_Done_Lane & en_q[I_Done_Idx]);
        end
        if (!v_q[I_Done_Idx] || |(I_Done_Lane & ~en_q[I_Done_Idx])) begin
          err_d = 1'b1;
        end
      end
      // Retire is applied after the merge so a late report on the head cannot survive the clear.
      if (retire) begin
        v_d[head_q]    = 1'b0;
        done_d[head_q] = '0;
        head_d         = head_q + 1'b1;
      end
      if (store_ack) begin
        v_d[tail_q]     = 1'b1;
        issue_d[tail_q] = I_Issue_No;
        en_d[tail_q]    = I_En_Lane;
        done_d[tail_q]  = '0;
        tail_d          = tail_q + 1'b1;
      end
      if (store_ack && !retire) begin
        cnt_d = cnt_q + 1'b1;
      end else if (retire && !store_ack) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q    <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        issue_q[i] <= '0;
        en_q[i]    <= '0;
        done_q[i]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        issue_q[i] <= issue_d[i];
        en_q[i]    <= en_d[i];
        done_q[i]  <= done_d[i];
      end
    end
  end

endmodule
